// File: rtl/cunit_pipe.sv
// cunit_pipe -- pipelined main control unit for the 5-stage MIPS core.
//
// Decodes the opcode held in IF/ID and carries the resulting control word
// through internal ID/EX, EX/MEM and MEM/WB registers, so each control group
// is presented in the stage that consumes it. Supports hazard stalls (bubble
// into ID/EX), branch flushes (kill ID/EX and EX/MEM), an illegal-opcode
// flag travelling with the EX-stage word, and a saturating bubble counter.
//
// Optional feature macro: CUNIT_JUMP_EN
//   defined   -> adds mem_jump output; opcode 000010 (J) decodes legally
//   undefined -> no mem_jump port; opcode 000010 is illegal
//
// Parameters:
//   OPW   opcode width (only the 6-bit MIPS encodings are legal; any set
//         upper bit makes the opcode illegal)
//   AOPW  ALU-op width (>= 3, table values zero-extended)
//   CNTW  bubble counter width
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   op_in, op_valid               opcode from IF/ID and its valid flag
//   stall, flush                  hazard bubble request, branch kill
//   ex_regds, ex_alusrc, ex_aop   EX-stage controls
//   ex_valid, illegal             EX stage holds a real / undecodable instr
//   mem_branch, mem_mread,
//   mem_mwrite, (mem_jump)        MEM-stage controls
//   wb_mtor, wb_urw               WB-stage controls
//   bubble_cnt                    stall/flush bubbles since reset, saturating
// All outputs are driven straight from registers.

module cunit_pipe #(
  parameter int unsigned OPW  = 6,
  parameter int unsigned AOPW = 3,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  op_in,
  input  logic            op_valid,
  input  logic            stall,
  input  logic            flush,
  output logic            ex_regds,
  output logic            ex_alusrc,
  output logic [AOPW-1:0] ex_aop,
  output logic            ex_valid,
  output logic            mem_branch,
  output logic            mem_mread,
  output logic            mem_mwrite,
`ifdef CUNIT_JUMP_EN
  output logic            mem_jump,
`endif
  output logic            wb_mtor,
  output logic            wb_urw,
  output logic            illegal,
  output logic [CNTW-1:0] bubble_cnt
);

  // Size-cast opcodes so that any nonzero upper bit (OPW > 6) fails to match.
  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SLTI  = OPW'(6'b001010);
`ifdef CUNIT_JUMP_EN
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
`endif

  // Full control word as held in ID/EX; an all-zero value is a bubble.
  typedef struct packed {
    logic            regds;
    logic            alusrc;
    logic [AOPW-1:0] aop;
    logic            valid;
    logic            illegal;
    logic            branch;
    logic            mread;
    logic            mwrite;
`ifdef CUNIT_JUMP_EN
    logic            jump;
`endif
    logic            mtor;
    logic            urw;
  } idex_t;

  // EX/MEM keeps only the MEM and WB groups.
  typedef struct packed {
    logic branch;
    logic mread;
    logic mwrite;
`ifdef CUNIT_JUMP_EN
    logic jump;
`endif
    logic mtor;
    logic urw;
  } exmem_t;

  typedef struct packed {
    logic mtor;
    logic urw;
  } memwb_t;

  idex_t           dec;
  idex_t           idex_q,  idex_d;
  exmem_t          exmem_q, exmem_d;
  memwb_t          memwb_q, memwb_d;
  logic [CNTW-1:0] cnt_q,   cnt_d;
  logic            bubble_req;

  // Opcode decode; fields not listed for an opcode stay 0.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (op_in)
      OP_RTYPE: begin
        dec.regds = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b010);
        dec.urw   = 1'b1;
      end
      OP_LW: begin
        dec.mread  = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b011);
        dec.alusrc = 1'b1; dec.urw  = 1'b1;
      end
      OP_SW: begin
        dec.regds  = 1'b1; dec.aop = AOPW'(3'b011); dec.mwrite = 1'b1;
        dec.alusrc = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1; dec.aop = AOPW'(3'b001);
      end
      OP_ADDI: begin
        dec.regds  = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b011);
        dec.alusrc = 1'b1; dec.urw  = 1'b1;
      end
      OP_ANDI: begin
        dec.regds  = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b101);
        dec.alusrc = 1'b1; dec.urw  = 1'b1;
      end
      OP_ORI: begin
        dec.regds  = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b110);
        dec.alusrc = 1'b1; dec.urw  = 1'b1;
      end
      OP_SLTI: begin
        dec.regds  = 1'b1; dec.mtor = 1'b1; dec.aop = AOPW'(3'b100);
        dec.alusrc = 1'b1; dec.urw  = 1'b1;
      end
`ifdef CUNIT_JUMP_EN
      OP_J: begin
        dec.jump = 1'b1;
      end
`endif
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Flush takes priority over stall, but both put a bubble into ID/EX and
  // both count; only flush also kills EX/MEM.
  assign bubble_req = flush | stall;

  always_comb begin
    idex_d  = '0;
    exmem_d = '0;
    memwb_d = '0;
    cnt_d   = cnt_q;

    if (!bubble_req && op_valid) begin
      idex_d = dec;
    end

    if (!flush) begin
      exmem_d.branch = idex_q.branch;
      exmem_d.mread  = idex_q.mread;
      exmem_d.mwrite = idex_q.mwrite;
`ifdef CUNIT_JUMP_EN
      exmem_d.jump   = idex_q.jump;
`endif
      exmem_d.mtor   = idex_q.mtor;
      exmem_d.urw    = idex_q.urw;
    end

    memwb_d.mtor = exmem_q.mtor;
    memwb_d.urw  = exmem_q.urw;

    if (bubble_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
      cnt_q   <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_regds   = idex_q.regds;
  assign ex_alusrc  = idex_q.alusrc;
  assign ex_aop     = idex_q.aop;
  assign ex_valid   = idex_q.valid;
  assign illegal    = idex_q.illegal;
  assign mem_branch = exmem_q.branch;
  assign mem_mread  = exmem_q.mread;
  assign mem_mwrite = exmem_q.mwrite;
`ifdef CUNIT_JUMP_EN
  assign mem_jump   = exmem_q.jump;
`endif
  assign wb_mtor    = memwb_q.mtor;
  assign wb_urw     = memwb_q.urw;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_cunit_pipe.sv
// Testbench for cunit_pipe: table-driven decode vectors checked through a
// per-stage scoreboard, plus hand-written reset/stall/flush/saturation cases.
// A second instance with CNTW=2 exercises counter saturation.

module tb_cunit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_in;
  logic       op_valid, stall, flush;

  logic       ex_regds, ex_alusrc, ex_valid, illegal;
  logic [2:0] ex_aop;
  logic       mem_branch, mem_mread, mem_mwrite, wb_mtor, wb_urw;
  logic [7:0] bubble_cnt;
  logic       jmp;

  logic       d2_regds, d2_alusrc, d2_valid, d2_illegal;
  logic [2:0] d2_aop;
  logic       d2_branch, d2_mread, d2_mwrite, d2_mtor, d2_urw;
  logic [1:0] d2_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef CUNIT_JUMP_EN
  logic mem_jump, d2_jump;
  assign jmp = mem_jump;
`else
  assign jmp = 1'b0;
`endif

  cunit_pipe dut (
    .clk(clk), .rst(rst), .op_in(op_in), .op_valid(op_valid),
    .stall(stall), .flush(flush),
    .ex_regds(ex_regds), .ex_alusrc(ex_alusrc), .ex_aop(ex_aop),
    .ex_valid(ex_valid),
    .mem_branch(mem_branch), .mem_mread(mem_mread), .mem_mwrite(mem_mwrite),
`ifdef CUNIT_JUMP_EN
    .mem_jump(mem_jump),
`endif
    .wb_mtor(wb_mtor), .wb_urw(wb_urw), .illegal(illegal),
    .bubble_cnt(bubble_cnt)
  );

  cunit_pipe #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .op_in(op_in), .op_valid(op_valid),
    .stall(stall), .flush(flush),
    .ex_regds(d2_regds), .ex_alusrc(d2_alusrc), .ex_aop(d2_aop),
    .ex_valid(d2_valid),
    .mem_branch(d2_branch), .mem_mread(d2_mread), .mem_mwrite(d2_mwrite),
`ifdef CUNIT_JUMP_EN
    .mem_jump(d2_jump),
`endif
    .wb_mtor(d2_mtor), .wb_urw(d2_urw), .illegal(d2_illegal),
    .bubble_cnt(d2_cnt)
  );

  // w bit order: RegDs, Branch, MRead, MtoR, AOp[2:0], MWrite, ALUsrc, Urw
  typedef struct packed {
    logic [5:0] op;
    logic       v;
    logic [9:0] w;
    logic       ev;
    logic       ill;
    logic       j;
  } vec_t;

  localparam int unsigned NV = 13;
  vec_t tbl [NV];

  logic [6:0] ex_q  [$];
  logic [3:0] mem_q [$];
  logic [1:0] wb_q  [$];

  logic [1:0] sat_exp [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; op_in = '0; op_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {ex_regds, ex_alusrc, ex_aop, ex_valid, illegal, mem_branch,
            mem_mread, mem_mwrite, jmp, wb_mtor, wb_urw, bubble_cnt};
  endfunction

  initial begin
    tbl[0]  = '{6'b000000, 1'b1, 10'b1_0_0_1_010_0_0_1, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{6'b100011, 1'b1, 10'b0_0_1_1_011_0_1_1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{6'b101011, 1'b1, 10'b1_0_0_0_011_1_1_0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{6'b000100, 1'b1, 10'b0_1_0_0_001_0_0_0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{6'b001000, 1'b1, 10'b1_0_0_1_011_0_1_1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{6'b001100, 1'b1, 10'b1_0_0_1_101_0_1_1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{6'b001101, 1'b1, 10'b1_0_0_1_110_0_1_1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{6'b001010, 1'b1, 10'b1_0_0_1_100_0_1_1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{6'b100011, 1'b0, 10'b0,                 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{6'b111111, 1'b1, 10'b0,                 1'b1, 1'b1, 1'b0};
`ifdef CUNIT_JUMP_EN
    tbl[10] = '{6'b000010, 1'b1, 10'b0,                 1'b1, 1'b0, 1'b1};
`else
    tbl[10] = '{6'b000010, 1'b1, 10'b0,                 1'b1, 1'b1, 1'b0};
`endif
    tbl[11] = '{6'b111111, 1'b0, 10'b0,                 1'b0, 1'b0, 1'b0};
    tbl[12] = '{6'b000000, 1'b0, 10'b0,                 1'b0, 1'b0, 1'b0};
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1'b1; op_in = '0; op_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("reset_outputs", all_outs(), 32'h0);
    #10;
    rst = 1'b0;

    // Decode table through the scoreboard; pipeline starts as bubbles.
    mem_q.push_back(4'h0);
    wb_q.push_back(2'h0);
    wb_q.push_back(2'h0);
    for (int i = 0; i < NV; i++) begin
      logic [6:0] ee;
      logic [3:0] em;
      logic [1:0] ew;
      op_in    = tbl[i].op;
      op_valid = tbl[i].v;
      ex_q.push_back({tbl[i].w[9], tbl[i].w[1], tbl[i].w[5:3], tbl[i].ev, tbl[i].ill});
      mem_q.push_back({tbl[i].w[8], tbl[i].w[7], tbl[i].w[2], tbl[i].j});
      wb_q.push_back({tbl[i].w[6], tbl[i].w[0]});
      edge1();
      ee = ex_q.pop_front();
      em = mem_q.pop_front();
      ew = wb_q.pop_front();
      chk($sformatf("vec%0d_ex", i),
          {25'b0, ex_regds, ex_alusrc, ex_aop, ex_valid, illegal}, {25'b0, ee});
      chk($sformatf("vec%0d_mem", i),
          {28'b0, mem_branch, mem_mread, mem_mwrite, jmp}, {28'b0, em});
      chk($sformatf("vec%0d_wb", i), {30'b0, wb_mtor, wb_urw}, {30'b0, ew});
    end
    chk("no_table_bubbles_counted", {24'b0, bubble_cnt}, 32'd0);

    // Mid-stream asynchronous reset.
    do_reset();
    stall = 1'b1;
    edge1();
    stall = 1'b0; op_in = 6'b100011; op_valid = 1'b1;
    edge1();
    chk("pre_reset_cnt", {24'b0, bubble_cnt}, 32'd1);
    chk("pre_reset_alusrc", {31'b0, ex_alusrc}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_outputs", all_outs(), 32'h0);
    rst = 1'b0; op_in = 6'b001000; op_valid = 1'b1;
    edge1();
    chk("post_reset_load", {28'b0, ex_aop, ex_valid}, {28'b0, 3'b011, 1'b1});

    // LW latency.
    do_reset();
    op_in = 6'b100011; op_valid = 1'b1;
    edge1();
    op_valid = 1'b0;
    chk("lw_ex", {28'b0, ex_alusrc, ex_aop}, {28'b0, 1'b1, 3'b011});
    edge1();
    chk("lw_mem", {31'b0, mem_mread}, 32'd1);
    edge1();
    chk("lw_wb", {30'b0, wb_mtor, wb_urw}, 32'd3);

    // Stall: R-type, stalled ADDI, ADDI.
    do_reset();
    op_in = 6'b000000; op_valid = 1'b1;
    edge1();
    op_in = 6'b001000; stall = 1'b1;
    edge1();
    chk("stall_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("stall_mem_rtype", {29'b0, mem_branch, mem_mread, mem_mwrite}, 32'd0);
    stall = 1'b0;
    edge1();
    op_valid = 1'b0;
    chk("stall_addi_ex", {27'b0, ex_aop, ex_alusrc, ex_valid}, {27'b0, 3'b011, 1'b1, 1'b1});
    chk("stall_rtype_wb", {30'b0, wb_mtor, wb_urw}, 32'd3);
    chk("stall_cnt", {24'b0, bubble_cnt}, 32'd1);

    // Flush over stall: SW, BEQ, then flush+stall.
    do_reset();
    op_in = 6'b101011; op_valid = 1'b1;
    edge1();
    op_in = 6'b000100;
    edge1();
    chk("flush_pre_sw_mem", {31'b0, mem_mwrite}, 32'd1);
    op_in = 6'b001000; flush = 1'b1; stall = 1'b1;
    edge1();
    chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("flush_mem_kill", {30'b0, mem_mwrite, mem_branch}, 32'd0);
    chk("flush_cnt", {24'b0, bubble_cnt}, 32'd1);
    stall = 1'b0;
    edge1();
    flush = 1'b0; op_valid = 1'b0;
    chk("flush_hold_cnt", {24'b0, bubble_cnt}, 32'd2);
    chk("flush_hold_ex", {31'b0, ex_valid}, 32'd0);

    // Saturation on the CNTW=2 instance.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      chk($sformatf("sat%0d", i), {30'b0, d2_cnt}, {30'b0, sat_exp[i]});
      chk($sformatf("cnt8_%0d", i), {24'b0, bubble_cnt}, i + 1);
    end
    stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
